fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
- Parametrised successor to the fixed 64-point, 32-bit FFT input and output staging logic.
- Accepts a whole frame as a flat bus from the SPI buffer, with a ping-pong pending slot so the next frame can land while the current one is processed.
- Streams the active frame into the FFT controller, pulses start and waits for done.
- Unloads results with a parametrised read latency, then holds the result frame until the SPI side acknowledges it.

Parameters:
- NPTS, 64, FFT points per frame; power of two, ≥4.
- WIDTH, 32, bits per complex word (re/im packed).
- RD_LAT, 2, cycles from fft_addr to valid fft_rdata during unload; 1..4.
- AW, $clog2(NPTS), address width (derived, not overridden).

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high.
- frame_in  in  NPTS*WIDTH  input frame; word i = bits [i*WIDTH +: WIDTH].
- frame_valid  in  1  one-cycle pulse; frame_in is valid this cycle.
- fft_load  out  1  high while words are being written to the core.
- fft_start  out  1  one-cycle start pulse to the core.
- fft_addr  out  AW  load address, or read address during unload.
- fft_wdata  out  WIDTH  word being loaded.
- fft_done  in  1  level from the core, high when the transform is complete.
- fft_rdata  in  WIDTH  result word from the core.
- frame_out  out  NPTS*WIDTH  result frame, same packing as frame_in.
- result_valid  out  1  frame_out is stable and complete.
- result_ack  in  1  one-cycle pulse from the SPI side releasing frame_out.
- busy  out  1  state != IDLE.
- overrun_cnt  out  8  saturating count of dropped frames.

Behaviour:
- Reset values: all outputs 0, frame_out 0, state IDLE, pending slot empty. Reset mid-operation aborts immediately, discards both buffers and clears overrun_cnt.
- Capture (independent of the FSM):
  - frame_valid with the pending slot empty: copy frame_in to the pending slot, mark it full.
  - frame_valid with the pending slot full: overwrite with the newest frame, overrun_cnt += 1, saturating at 255.
- FSM states: IDLE, LOAD, START, WAIT, UNLOAD, HOLD.
- IDLE: if the pending slot is full, move it to the active buffer, empty the slot, go to LOAD next cycle. If frame_valid coincides with the move, the new frame lands in the now-empty slot with no overrun.
- LOAD: takes NPTS cycles, k = 0..NPTS-1.
  - fft_load=1, fft_addr=k, fft_wdata=active word k.
  - After k=NPTS-1, go to START.
- START: fft_load=0, fft_start=1 for exactly one cycle, then WAIT.
- WAIT: stay until fft_done=1, then UNLOAD. fft_done already high on the cycle after START is legal and advances the FSM.
- UNLOAD: takes NPTS+RD_LAT cycles.
  - Issue fft_addr=0..NPTS-1 on consecutive cycles.
  - An RD_LAT-deep address/valid pipeline writes fft_rdata into word addr of frame_out.
  - Go to HOLD after the final write.
- HOLD: result_valid=1 and frame_out is frozen.
  - On result_ack, result_valid drops the next cycle.
  - Then go to LOAD directly if the pending slot is full (same transfer as IDLE), else go to IDLE.
- result_ack outside HOLD is ignored.
- frame_out changes only in UNLOAD; result_valid is 0 throughout UNLOAD.
- Minimum frame period with an immediate ack: NPTS + 1 + wait + NPTS + RD_LAT + 2 cycles.

Decomposition:
- Shared package fft_pkg holds:
  - state enum fft_seq_state_t (IDLE, LOAD, START, WAIT, UNLOAD, HOLD);
  - default constants FFT_NPTS=64, FFT_WIDTH=32;
  - OVR_MAX=8'hFF.
- One natural sub-module: fft_rd_pipe, a parametrised RD_LAT-stage delay of {valid, addr} that aligns write-enables with fft_rdata.
- The capture logic and FSM stay in the top module.

Test Plan (NPTS=64, WIDTH=32, RD_LAT=2):
- Basic frame: reset, then frame_valid with word i=32'h1000_0000+i.
  - Required: LOAD addresses 0..63 with wdata matching, then one fft_start pulse.
  - Model returns rdata=~addr after 2 cycles; required frame_out word i=~i and result_valid=1.
- Done latency: fft_done asserted 1 cycle after START and, separately, 500 cycles after START.
  - Required: UNLOAD begins the cycle after done in both cases.
- Back-to-back frames: a second frame_valid during WAIT of the first.
  - Required: overrun_cnt=0; the second LOAD begins the cycle after result_ack, with no IDLE visit.
- Overrun: three frame_valid pulses during one WAIT.
  - Required: overrun_cnt=2 and the next frame processed is the third.
  - With 300 drops, overrun_cnt saturates at 255.
- Reset mid-UNLOAD (address 20): outputs 0, state IDLE, pending slot empty.
  - A fresh frame afterwards processes normally.
- Ack handling: result_ack pulsed during LOAD is ignored.
  - In HOLD, frame_out stays stable across 100 cycles until the ack; result_valid falls 1 cycle after it.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT frame sequencer slice.
package fft_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      UNLOAD,
      HOLD
   } fft_seq_state_t;

   localparam int         FFT_NPTS  = 64;
   localparam int         FFT_WIDTH = 32;
   localparam logic [7:0] OVR_MAX   = 8'hFF;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Word-level bus between the frame sequencer (master) and the FFT core (slave).
interface fft_frame_sequencer_if
   import fft_pkg::*;
#(
   parameter int WIDTH = FFT_WIDTH,
   parameter int AW    = $clog2(FFT_NPTS)
) ();

   logic             fft_load;
   logic             fft_start;
   logic [AW-1:0]    fft_addr;
   logic [WIDTH-1:0] fft_wdata;
   logic             fft_done;
   logic [WIDTH-1:0] fft_rdata;

   modport master (
      output fft_load, fft_start, fft_addr, fft_wdata,
      input  fft_done, fft_rdata
   );

   modport slave (
      input  fft_load, fft_start, fft_addr, fft_wdata,
      output fft_done, fft_rdata
   );

endinterface

// File: rtl/fft_rd_pipe.sv
// RD_LAT-stage delay of {valid, addr} so result writes line up with fft_rdata.
module fft_rd_pipe
   import fft_pkg::*;
#(
   parameter int AW     = $clog2(FFT_NPTS),
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   output logic          out_valid,
   output logic [AW-1:0] out_addr
);

   logic [RD_LAT-1:0] vld_q;
   logic [AW-1:0]     addr_q [RD_LAT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= in_valid;
         for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   // Addresses are qualified by vld_q, so they carry no reset.
   always_ff @(posedge clk) begin
      addr_q[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) addr_q[i] <= addr_q[i-1];
   end

   assign out_valid = vld_q[RD_LAT-1];
   assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/fft_frame_sequencer.sv
// Double-buffered frame capture, FFT core load/start/unload sequencing and
// result hold until acknowledged by the SPI side.
module fft_frame_sequencer
   import fft_pkg::*;
#(
   parameter int  NPTS   = FFT_NPTS,
   parameter int  WIDTH  = FFT_WIDTH,
   parameter int  RD_LAT = 2,
   localparam int AW     = $clog2(NPTS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NPTS*WIDTH-1:0] frame_in,
   input  logic                  frame_valid,
   fft_frame_sequencer_if.master fft,
   output logic [NPTS*WIDTH-1:0] frame_out,
   output logic                  result_valid,
   input  logic                  result_ack,
   output logic                  busy,
   output logic [7:0]            overrun_cnt
);

   // One spare bit lets the unload count run past NPTS for the read latency.
   localparam int            CW          = AW + 1;
   localparam logic [CW-1:0] LOAD_LAST   = CW'(NPTS - 1);
   localparam logic [CW-1:0] UNLOAD_LAST = CW'(NPTS + RD_LAT - 1);
   localparam logic [CW-1:0] NPTS_C      = CW'(NPTS);

   fft_seq_state_t        state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NPTS*WIDTH-1:0] pend_data, active;
   logic                  pend_full;
   logic                  take;
   logic                  load, start, rd_issue;
   logic [AW-1:0]         addr;
   logic [WIDTH-1:0]      wdata;
   logic                  wr_en;
   logic [AW-1:0]         wr_addr;

   // Pending slot moves to the active buffer from IDLE, or straight out of HOLD on ack.
   assign take = pend_full && ((state_q == IDLE) || (state_q == HOLD && result_ack));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_full   <= 1'b0;
         overrun_cnt <= '0;
      end else if (frame_valid) begin
         pend_full <= 1'b1;
         if (pend_full && !take && overrun_cnt != OVR_MAX) overrun_cnt <= overrun_cnt + 8'd1;
      end else if (take) begin
         pend_full <= 1'b0;
      end
   end

   // NOTE: wide data buffers are deliberately unreset; pend_full and the FSM
   // state say whether their contents mean anything.
   always_ff @(posedge clk) begin
      if (frame_valid) pend_data <= frame_in;
      if (take)        active    <= pend_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load     = 1'b0;
      start    = 1'b0;
      rd_issue = 1'b0;
      addr     = '0;
      wdata    = '0;
      case (state_q)
         IDLE: begin
            if (take) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            load  = 1'b1;
            addr  = cnt_q[AW-1:0];
            wdata = active[int'(cnt_q[AW-1:0])*WIDTH +: WIDTH];
            if (cnt_q == LOAD_LAST) begin
               state_d = START;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         START: begin
            start   = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (fft.fft_done) begin
               state_d = UNLOAD;
               cnt_d   = '0;
            end
         end
         UNLOAD: begin
            if (cnt_q < NPTS_C) begin
               rd_issue = 1'b1;
               addr     = cnt_q[AW-1:0];
            end
            if (cnt_q == UNLOAD_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (result_ack) begin
               state_d = pend_full ? LOAD : IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   fft_rd_pipe #(
      .AW     (AW),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rd_issue),
      .in_addr   (addr),
      .out_valid (wr_en),
      .out_addr  (wr_addr)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_out <= '0;
      end else if (wr_en && state_q == UNLOAD) begin
         frame_out[int'(wr_addr)*WIDTH +: WIDTH] <= fft.fft_rdata;
      end
   end

   assign fft.fft_load  = load;
   assign fft.fft_start = start;
   assign fft.fft_addr  = addr;
   assign fft.fft_wdata = wdata;
   assign result_valid  = (state_q == HOLD);
   assign busy          = (state_q != IDLE);

endmodule
